// File: rtl/rv32i_instruction_loader.sv
// Byte-stream instruction loader: length header, little-endian words, XOR trailer.
// Holds the core in reset while words are pushed into instruction memory.
module rv32i_instruction_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'd0,
    parameter int          MAX_WORDS  = 1024,
    parameter int          WR_TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic        o_byte_ready,
    output logic        o_instruction_wr_en,
    output logic [31:0] o_instruction_wr_addr,
    output logic [31:0] o_instruction_wr_data,
    input  logic        i_instruction_wr_valid,
    output logic        o_core_rst,
    output logic        o_load_done,
    output logic        o_load_error
);

    localparam int TW = $clog2(WR_TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(WR_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, HDR, DATA, WRITE, CHK, DONE, ERR
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   word_q, word_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [7:0]    chk_q, chk_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic        xfer;
    logic [31:0] asm_w;

    // Bytes arrive LSB first, so each new byte enters at the top.
    assign asm_w = {i_byte_data, word_q[31:8]};
    assign xfer  = i_byte_valid & o_byte_ready;

    assign o_byte_ready = (state_q == HDR) || (state_q == DATA)
                       || (state_q == CHK);
    assign o_core_rst            = o_byte_ready || (state_q == WRITE);
    assign o_instruction_wr_en   = (state_q == WRITE);
    assign o_instruction_wr_addr = addr_q;
    assign o_instruction_wr_data = wdata_q;
    assign o_load_done           = (state_q == DONE);
    assign o_load_error          = (state_q == ERR);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            chk_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            chk_q   <= chk_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        chk_d   = chk_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (i_load_start) begin
                    state_d = HDR;
                    idx_d   = '0;
                    word_d  = '0;
                    chk_d   = '0;
                end
            end
            HDR: begin
                if (xfer) begin
                    word_d = asm_w;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (asm_w == 32'd0) begin
                            state_d = DONE;
                        end else if (asm_w > 32'(MAX_WORDS)) begin
                            state_d = ERR;
                        end else begin
                            state_d = DATA;
                            addr_d  = BASE_ADDR;
                            cnt_d   = asm_w;
                        end
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    word_d = asm_w;
                    chk_d  = chk_q ^ i_byte_data;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        wdata_d = asm_w;
                        tmo_d   = '0;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                // An acknowledge on the last allowed cycle still counts.
                if (i_instruction_wr_valid) begin
                    addr_d  = addr_q + 32'd4;
                    cnt_d   = cnt_q - 32'd1;
                    state_d = (cnt_q == 32'd1) ? CHK : DATA;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            CHK: begin
                if (xfer) begin
                    state_d = (i_byte_data == chk_q) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rv32i_instruction_loader.sv
// Directed table-driven bench for rv32i_instruction_loader with an
// instruction-memory responder that acks after a programmable delay.
module tb_rv32i_instruction_loader;

    localparam int WR_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        bv;
    logic [7:0]  bd;
    logic        br;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        wv = 1'b0;
    logic        crst;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    rv32i_instruction_loader #(
        .BASE_ADDR (32'd0),
        .MAX_WORDS (1024),
        .WR_TIMEOUT(WR_TIMEOUT)
    ) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_load_start          (start),
        .i_byte_valid          (bv),
        .i_byte_data           (bd),
        .o_byte_ready          (br),
        .o_instruction_wr_en   (we),
        .o_instruction_wr_addr (wa),
        .o_instruction_wr_data (wd),
        .i_instruction_wr_valid(wv),
        .o_core_rst            (crst),
        .o_load_done           (done),
        .o_load_error          (err)
    );

    int          nvec = 0;
    int          nmis = 0;
    int          ack_delay = 2;
    int          wcnt = 0;
    int          wr_cycles = 0;
    logic [63:0] wlog[$];

    // Memory model: ack after ack_delay cycles of wr_en (0 = never ack).
    always @(negedge clk) begin
        if (we) begin
            wr_cycles++;
            wcnt++;
            if (ack_delay != 0 && wcnt == ack_delay) begin
                wv = 1'b1;
                wlog.push_back({wa, wd});
            end else begin
                wv = 1'b0;
            end
        end else begin
            wcnt = 0;
            wv   = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        bv = 1'b1;
        bd = b;
        for (int t = 0; t < 300 && !ok; t++) begin
            if (br) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bv = 1'b0;
        if (!ok) begin
            nvec++;
            nmis++;
            $display("FAIL send_byte: ready got 0 required 1");
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic start_load();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end();
        for (int t = 0; t < 300 && !(done || err); t++) begin
            @(posedge clk);
            #1;
        end
        if (!(done || err)) begin
            nvec++;
            nmis++;
            $display("FAIL wait_end: done|err got 0 required 1");
        end
    endtask

    function automatic logic [7:0] xsum(input logic [31:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction

    typedef struct {
        string       nm;
        logic [31:0] n;
        int          nsend;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          trailer;
        bit          bad;
        int          dly;
        logic        exp_done;
        logic        exp_err;
        int          exp_wr;
    } vec_t;

    vec_t v[6];

    task automatic run_vec(input int i);
        logic [7:0]  cs;
        logic [31:0] w;
        logic [31:0] ew;
        int          ecyc;
        ack_delay = v[i].dly;
        wlog.delete();
        wr_cycles = 0;
        cs = 8'h00;
        start_load();
        chk({v[i].nm, " core_rst_on"}, 64'(crst), 64'd1);
        chk({v[i].nm, " flags_clr"}, 64'({done, err}), 64'd0);
        send_word(v[i].n);
        for (int k = 0; k < v[i].nsend; k++) begin
            w  = (k == 0) ? v[i].w0 : v[i].w1;
            cs = cs ^ xsum(w);
            send_word(w);
        end
        if (v[i].trailer) send_byte(v[i].bad ? (cs ^ 8'h01) : cs);
        wait_end();
        chk({v[i].nm, " done"}, 64'(done), 64'(v[i].exp_done));
        chk({v[i].nm, " error"}, 64'(err), 64'(v[i].exp_err));
        chk({v[i].nm, " core_rst"}, 64'(crst), 64'd0);
        chk({v[i].nm, " wr_en"}, 64'(we), 64'd0);
        chk({v[i].nm, " nwrites"}, 64'(wlog.size()), 64'(v[i].exp_wr));
        ecyc = (v[i].dly == 0) ? WR_TIMEOUT : v[i].exp_wr * v[i].dly;
        chk({v[i].nm, " wr_cycles"}, 64'(wr_cycles), 64'(ecyc));
        for (int k = 0; k < wlog.size() && k < v[i].exp_wr; k++) begin
            ew = (k == 0) ? v[i].w0 : v[i].w1;
            chk({v[i].nm, " write"}, wlog[k], {32'(4 * k), ew});
        end
    endtask

    initial begin
        v[0] = '{"two_words", 32'd2, 2, 32'h00000013, 32'h00100093,
                 1'b1, 1'b0, 2, 1'b1, 1'b0, 2};
        v[1] = '{"zero_hdr", 32'd0, 0, 32'h0, 32'h0,
                 1'b0, 1'b0, 2, 1'b1, 1'b0, 0};
        v[2] = '{"too_many", 32'd1025, 0, 32'h0, 32'h0,
                 1'b0, 1'b0, 2, 1'b0, 1'b1, 0};
        v[3] = '{"bad_chk", 32'd2, 2, 32'h00000013, 32'h00100093,
                 1'b1, 1'b1, 2, 1'b0, 1'b1, 2};
        v[4] = '{"timeout", 32'd1, 1, 32'hCAFEF00D, 32'h0,
                 1'b0, 1'b0, 0, 1'b0, 1'b1, 0};
        v[5] = '{"one_fast", 32'd1, 1, 32'hDEADBEEF, 32'h0,
                 1'b1, 1'b0, 1, 1'b1, 1'b0, 1};

        rst   = 1'b1;
        start = 1'b0;
        bv    = 1'b0;
        bd    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst ready", 64'(br), 64'd0);
        chk("rst wr_en", 64'(we), 64'd0);
        chk("rst addr", 64'(wa), 64'd0);
        chk("rst data", 64'(wd), 64'd0);
        chk("rst core_rst", 64'(crst), 64'd0);
        chk("rst flags", 64'({done, err}), 64'd0);

        // Start offered on the very first edge after reset release.
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("first_start core_rst", 64'(crst), 64'd1);
        send_word(32'd0);
        wait_end();
        chk("first_start done", 64'(done), 64'd1);

        for (int i = 0; i < 6; i++) run_vec(i);

        // N == MAX_WORDS is legal: loader must enter DATA.
        start_load();
        send_word(32'd1024);
        chk("max ready", 64'(br), 64'd1);
        chk("max core_rst", 64'(crst), 64'd1);
        chk("max error", 64'(err), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // A start mid-DATA must be ignored.
        ack_delay = 2;
        wlog.delete();
        start_load();
        send_word(32'd1);
        send_byte(8'hEF);
        start_load();
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        send_byte(xsum(32'hDEADBEEF));
        wait_end();
        chk("ign_start done", 64'(done), 64'd1);
        chk("ign_start nwrites", 64'(wlog.size()), 64'd1);
        if (wlog.size() > 0)
            chk("ign_start write", wlog[0], {32'd0, 32'hDEADBEEF});

        // Asynchronous reset mid-DATA with valid held high.
        start_load();
        send_word(32'd2);
        send_byte(8'h13);
        bv = 1'b1;
        bd = 8'h00;
        #3;
        rst = 1'b1;
        #1;
        chk("arst ready", 64'(br), 64'd0);
        chk("arst wr_en", 64'(we), 64'd0);
        chk("arst addr_data", {wa, wd}, 64'd0);
        chk("arst core_rst", 64'(crst), 64'd0);
        chk("arst flags", 64'({done, err}), 64'd0);
        @(negedge clk);
        bv  = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
